// File: rtl/wdt_sleep_ctrl.sv
// Run-state sequencer for a PIC16C5x core: core reset/enable, watchdog with
// prescaler, SLEEP/CLRWDT handling and the STATUS TO/PD flags.
module wdt_sleep_ctrl #(
  parameter int WDT_WIDTH    = 8,
  parameter int PS_MAX_WIDTH = 7,
  parameter int POR_CYCLES   = 16,
  parameter int RST_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          instIn,
  input  logic                 instStrobe,
  input  logic [3:0]           optionIn,
  input  logic                 wdtEnable,
  input  logic                 wakeIn,
  output logic                 coreRstOut,
  output logic                 coreEnOut,
  output logic                 toOut,
  output logic                 pdOut,
  output logic [1:0]           stateOut,
  output logic [WDT_WIDTH-1:0] wdtCountOut
);

  typedef enum logic [1:0] {
    ST_POR   = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WRST  = 2'd3
  } state_t;

  localparam int HOLD_MAX = (POR_CYCLES > RST_CYCLES) ? POR_CYCLES : RST_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int CMP_W    = (PS_MAX_WIDTH > 8) ? PS_MAX_WIDTH : 8;

  state_t                  r_state;
  logic [HOLD_W-1:0]       r_holdCnt;
  logic [PS_MAX_WIDTH-1:0] r_psCnt;
  logic [WDT_WIDTH-1:0]    r_wdtCnt;
  logic                    r_coreRst;
  logic                    r_coreEn;
  logic                    r_to;
  logic                    r_pd;

  state_t                  w_nextState;
  logic [HOLD_W-1:0]       w_nextHold;
  logic [PS_MAX_WIDTH-1:0] w_nextPs;
  logic [WDT_WIDTH-1:0]    w_nextWdt;
  logic                    w_nextTo;
  logic                    w_nextPd;
  logic                    w_nextCoreRst;
  logic                    w_nextCoreEn;

  logic                    w_active;
  logic [CMP_W-1:0]        w_psLimit;
  logic [CMP_W-1:0]        w_psCntExt;
  logic                    w_tick;
  logic                    w_timeout;
  logic                    w_clrwdt;
  logic                    w_sleep;

  // Prescaler compares with >= so lowering PS mid-count still produces a tick
  assign w_active   = ((r_state == ST_RUN) || (r_state == ST_SLEEP)) && wdtEnable;
  assign w_psLimit  = (CMP_W'(1) << optionIn[2:0]) - CMP_W'(1);
  assign w_psCntExt = CMP_W'(r_psCnt);
  assign w_tick     = w_active && (!optionIn[3] || (w_psCntExt >= w_psLimit));
  assign w_timeout  = w_tick && (r_wdtCnt == '1);
  assign w_clrwdt   = instStrobe && (instIn == 12'h004);
  assign w_sleep    = instStrobe && (instIn == 12'h003);

  always_comb begin
    w_nextState = r_state;
    w_nextHold  = r_holdCnt;
    w_nextPs    = r_psCnt;
    w_nextWdt   = r_wdtCnt;
    w_nextTo    = r_to;
    w_nextPd    = r_pd;

    if (w_active) begin
      if (w_tick) begin
        w_nextPs  = '0;
        w_nextWdt = r_wdtCnt + WDT_WIDTH'(1);
      end else begin
        w_nextPs  = r_psCnt + PS_MAX_WIDTH'(1);
      end
    end

    case (r_state)
      ST_POR: begin
        w_nextPs  = '0;
        w_nextWdt = '0;
        if (r_holdCnt == HOLD_W'(POR_CYCLES - 1)) begin
          w_nextState = ST_RUN;
          w_nextHold  = '0;
        end else begin
          w_nextHold  = r_holdCnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        // An explicit clear or SLEEP in the timeout cycle suppresses the reset
        if (w_clrwdt) begin
          w_nextPs  = '0;
          w_nextWdt = '0;
          w_nextTo  = 1'b1;
          w_nextPd  = 1'b1;
        end else if (w_sleep) begin
          w_nextPs    = '0;
          w_nextWdt   = '0;
          w_nextTo    = 1'b1;
          w_nextPd    = 1'b0;
          w_nextState = ST_SLEEP;
        end else if (w_timeout) begin
          w_nextPs    = '0;
          w_nextWdt   = '0;
          w_nextHold  = '0;
          w_nextTo    = 1'b0;
          w_nextPd    = 1'b1;
          w_nextState = ST_WRST;
        end
      end
      ST_SLEEP: begin
        if (w_timeout) begin
          w_nextPs    = '0;
          w_nextWdt   = '0;
          w_nextHold  = '0;
          w_nextTo    = 1'b0;
          w_nextPd    = 1'b0;
          w_nextState = ST_WRST;
        end else if (wakeIn) begin
          w_nextPs    = '0;
          w_nextWdt   = '0;
          w_nextHold  = '0;
          w_nextTo    = 1'b1;
          w_nextPd    = 1'b0;
          w_nextState = ST_WRST;
        end
      end
      ST_WRST: begin
        w_nextPs  = '0;
        w_nextWdt = '0;
        if (r_holdCnt == HOLD_W'(RST_CYCLES - 1)) begin
          w_nextState = ST_RUN;
          w_nextHold  = '0;
        end else begin
          w_nextHold  = r_holdCnt + HOLD_W'(1);
        end
      end
      default: begin
        w_nextState = ST_POR;
        w_nextHold  = '0;
        w_nextPs    = '0;
        w_nextWdt   = '0;
      end
    endcase

    w_nextCoreRst = (w_nextState == ST_POR) || (w_nextState == ST_WRST);
    w_nextCoreEn  = (w_nextState == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_POR;
      r_holdCnt <= '0;
      r_psCnt   <= '0;
      r_wdtCnt  <= '0;
      r_coreRst <= 1'b1;
      r_coreEn  <= 1'b0;
      r_to      <= 1'b1;
      r_pd      <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= w_nextHold;
      r_psCnt   <= w_nextPs;
      r_wdtCnt  <= w_nextWdt;
      r_coreRst <= w_nextCoreRst;
      r_coreEn  <= w_nextCoreEn;
      r_to      <= w_nextTo;
      r_pd      <= w_nextPd;
    end
  end

  assign coreRstOut  = r_coreRst;
  assign coreEnOut   = r_coreEn;
  assign toOut       = r_to;
  assign pdOut       = r_pd;
  assign stateOut    = r_state;
  assign wdtCountOut = r_wdtCnt;

endmodule

// File: tb/tb_wdt_sleep_ctrl.sv
// Scoreboard bench for wdt_sleep_ctrl: stimulus queues expected output snapshots
// by cycle; the monitor checks them on every output change or due snapshot.
module tb_wdt_sleep_ctrl;

  localparam logic [1:0] POR = 2'd0, RUN = 2'd1, SLP = 2'd2, WRS = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instIn;
  logic        instStrobe;
  logic [3:0]  optionIn;
  logic        wdtEnable;
  logic        wakeIn;
  logic        coreRstOut;
  logic        coreEnOut;
  logic        toOut;
  logic        pdOut;
  logic [1:0]  stateOut;
  logic [3:0]  wdtCountOut;

  wdt_sleep_ctrl #(
    .WDT_WIDTH   (4),
    .PS_MAX_WIDTH(7),
    .POR_CYCLES  (4),
    .RST_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instIn     (instIn),
    .instStrobe (instStrobe),
    .optionIn   (optionIn),
    .wdtEnable  (wdtEnable),
    .wakeIn     (wakeIn),
    .coreRstOut (coreRstOut),
    .coreEnOut  (coreEnOut),
    .toOut      (toOut),
    .pdOut      (pdOut),
    .stateOut   (stateOut),
    .wdtCountOut(wdtCountOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       crst;
    logic       cen;
    logic       to;
    logic       pd;
    logic [3:0] wdt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [5:0] prev = 6'h3f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [1:0] st, input logic crst,
                           input logic cen, input logic to, input logic pd,
                           input logic [3:0] w, input string tag);
    exp_t e;
    e.cyc = c; e.st = st; e.crst = crst; e.cen = cen;
    e.to = to; e.pd = pd; e.wdt = w; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [11:0] code);
    instIn = code;
    instStrobe = 1'b1;
    @(negedge clk);
    instStrobe = 1'b0;
    instIn = 12'h000;
  endtask

  // Monitor: an output change or a due snapshot consumes one expectation
  always @(negedge clk) begin
    logic [5:0] cur;
    logic       changed;
    exp_t       e;
    cur = {stateOut, coreRstOut, coreEnOut, toOut, pdOut};
    changed = (cur !== prev);
    prev = cur;
    if (changed || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got state=%0d rst=%b en=%b to=%b pd=%b, required no change",
                 cyc, stateOut, coreRstOut, coreEnOut, toOut, pdOut);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || stateOut !== e.st || coreRstOut !== e.crst ||
            coreEnOut !== e.cen || toOut !== e.to || pdOut !== e.pd ||
            wdtCountOut !== e.wdt) begin
          n_err++;
          $display("FAIL %s: got cyc=%0d state=%0d rst=%b en=%b to=%b pd=%b wdt=%0d, required cyc=%0d state=%0d rst=%b en=%b to=%b pd=%b wdt=%0d",
                   e.tag, cyc, stateOut, coreRstOut, coreEnOut, toOut, pdOut, wdtCountOut,
                   e.cyc, e.st, e.crst, e.cen, e.to, e.pd, e.wdt);
        end
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1; instIn = 12'h000; instStrobe = 1'b0;
    optionIn = 4'b0000; wdtEnable = 1'b1; wakeIn = 1'b0;
    expect_at(1, POR, 1, 0, 1, 1, 0, "reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-on hold, then an unserviced watchdog
    expect_at(7,  RUN, 0, 1, 1, 1, 0, "por_exit");
    expect_at(23, WRS, 1, 0, 0, 1, 0, "run_timeout");
    expect_at(25, RUN, 0, 1, 0, 1, 0, "wrst_exit");
    wait_cyc(26);

    // Periodic CLRWDT keeps the core running
    expect_at(27,  RUN, 0, 1, 1, 1, 0, "clrwdt_first");
    expect_at(226, RUN, 0, 1, 1, 1, 9, "clrwdt_loop_end");
    for (int i = 0; i < 20; i++) begin
      pulse(12'h004);
      repeat (9) @(negedge clk);
    end
    expect_at(232, RUN, 0, 1, 1, 1, 15, "wdt_at_15");
    expect_at(233, RUN, 0, 1, 1, 1, 0,  "clrwdt_beats_timeout");
    wait_cyc(232);
    pulse(12'h004);

    // SLEEP then wake
    expect_at(234, SLP, 0, 0, 1, 0, 0, "sleep_entry");
    expect_at(238, SLP, 0, 0, 1, 0, 4, "sleep_counting");
    expect_at(240, WRS, 1, 0, 1, 0, 0, "wake_reset");
    expect_at(242, RUN, 0, 1, 1, 0, 0, "wake_exit");
    pulse(12'h003);
    wait_cyc(239);
    wakeIn = 1'b1;
    @(negedge clk);
    wakeIn = 1'b0;
    wait_cyc(242);

    // Prescaler 1:2 in SLEEP; timeout coincides with wake and wins
    optionIn = 4'b1001;
    expect_at(243, SLP, 0, 0, 1, 0, 0, "sleep_ps2");
    expect_at(259, SLP, 0, 0, 1, 0, 8, "ps2_mid");
    expect_at(275, WRS, 1, 0, 0, 0, 0, "ps2_timeout_beats_wake");
    expect_at(277, RUN, 0, 1, 0, 0, 0, "ps2_exit");
    expect_at(290, RUN, 0, 1, 0, 0, 2, "wdt_frozen");
    pulse(12'h003);
    wait_cyc(274);
    wakeIn = 1'b1;
    @(negedge clk);
    wakeIn = 1'b0;
    wait_cyc(281);
    wdtEnable = 1'b0;
    wait_cyc(290);

    // Disabled watchdog: SLEEP persists
    expect_at(291, SLP, 0, 0, 1, 0, 0, "sleep_nowdt");
    expect_at(791, SLP, 0, 0, 1, 0, 0, "sleep_500");
    pulse(12'h003);
    wait_cyc(791);

    // Reset during SLEEP and during WRST
    rst = 1'b1;
    expect_at(792, POR, 1, 0, 1, 1, 0, "rst_in_sleep");
    expect_at(796, RUN, 0, 1, 1, 1, 0, "por_exit2");
    expect_at(812, WRS, 1, 0, 0, 1, 0, "run_timeout2");
    expect_at(813, POR, 1, 0, 1, 1, 0, "rst_in_wrst");
    expect_at(817, RUN, 0, 1, 1, 1, 0, "por_exit3");
    @(negedge clk);
    rst = 1'b0;
    wdtEnable = 1'b1;
    optionIn = 4'b0000;
    wait_cyc(812);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(825);

    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: expectation for cyc=%0d never consumed, required state=%0d",
               e.tag, e.cyc, e.st);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wdt_sleep_ctrl.md
Name: wdt_sleep_ctrl

Overview:
Run-state sequencer for the PIC16C5x core. It owns the core reset and clock-enable, the watchdog timer with its prescaler, and SLEEP/CLRWDT handling. It sits beside the core top level: it watches the executing instruction and drives the core reset/enable and the STATUS TO/PD bits. Its reset is the only path that produces power-on flag values.

Parameters:
WDT_WIDTH, 8, width of the watchdog counter; a timeout happens on overflow.
PS_MAX_WIDTH, 7, width of the prescaler counter (maximum ratio 1:128).
POR_CYCLES, 16, number of cycles the core reset is held after power-on reset; must be at least 1.
RST_CYCLES, 4, number of cycles the core reset is held after a watchdog or wake reset; must be at least 1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
instIn  in  12  instruction currently in IR.
instStrobe  in  1  one-cycle pulse marking the cycle in which instIn executes.
optionIn  in  4  OPTION bits [3]=PSA and [2:0]=PS.
wdtEnable  in  1  configuration fuse; 0 stops the watchdog.
wakeIn  in  1  external wake request (level).
coreRstOut  out  1  active-high reset to the core.
coreEnOut  out  1  clock enable to the core.
toOut  out  1  STATUS TO bit.
pdOut  out  1  STATUS PD bit.
stateOut  out  2  current state: POR=0, RUN=1, SLEEP=2, WRST=3.
wdtCountOut  out  WDT_WIDTH  current watchdog count (debug).

Behaviour:
- All outputs are registered.
- Reset (rst=1): state=POR, holdCnt=0, psCnt=0, wdtCnt=0, coreRstOut=1, coreEnOut=0, toOut=1, pdOut=1. Reset asserted in any state (including mid-SLEEP or mid-WRST) gives this same result.
- POR state: coreRstOut=1, coreEnOut=0. holdCnt increments each cycle. When holdCnt reaches POR_CYCLES-1, the next state is RUN and holdCnt is cleared. The core reset therefore spans exactly POR_CYCLES cycles after rst deasserts.
- RUN state: coreRstOut=0, coreEnOut=1.
  - CLRWDT (instStrobe=1 and instIn=12'h004): clear wdtCnt and psCnt; set toOut=1 and pdOut=1.
  - SLEEP (instStrobe=1 and instIn=12'h003): clear wdtCnt and psCnt; set toOut=1 and pdOut=0; next state is SLEEP.
  - Timeout: next state is WRST, with toOut=0 and pdOut=1.
  - instIn is ignored when instStrobe=0, and in every state other than RUN.
- SLEEP state: coreRstOut=0, coreEnOut=0. The watchdog keeps counting.
  - wakeIn=1: next state is WRST, with toOut=1 and pdOut=0.
  - Timeout: next state is WRST, with toOut=0 and pdOut=0.
  - If wakeIn and a timeout occur in the same cycle, the timeout wins (TO=0).
- WRST state: coreRstOut=1, coreEnOut=0. Flags are held. Same hold-counter scheme as POR but using RST_CYCLES; then the next state is RUN. wdtCnt and psCnt are cleared on entry and stay cleared during WRST.
- Watchdog tick (RUN and SLEEP only, and only when wdtEnable=1):
  - ratio = PSA ? (1<<PS) : 1.
  - tick = (PSA==0) or (psCnt >= ratio-1). Using >= keeps a mid-run PS decrease from stalling the prescaler.
  - On a tick, psCnt is cleared; otherwise psCnt increments.
  - On a tick, wdtCnt increments and wraps.
  - Timeout = tick and wdtCnt == all ones.
  - With PSA=0, WRST is entered exactly 2^WDT_WIDTH cycles after the clearing edge; with the prescaler, ratio·2^WDT_WIDTH cycles.
- wdtEnable=0: counters are frozen (not cleared) and no timeout occurs. SLEEP is exited only by wakeIn.
- Priority in RUN when events coincide: SLEEP or CLRWDT beats a timeout in the same cycle (the clear wins, no reset). wakeIn in RUN is ignored.
- State transitions and flag updates take effect on the same clock edge. coreRstOut and coreEnOut change on that edge together with stateOut.

Test Plan:
Bench parameters: WDT_WIDTH=4, POR_CYCLES=4, RST_CYCLES=2, wdtEnable=1, PSA=0.
- Release rst -> coreRstOut=1 for 4 cycles, then stateOut=1, coreEnOut=1, toOut=1, pdOut=1.
- No CLRWDT -> stateOut=3 exactly 16 cycles after RUN entry, toOut=0, pdOut=1; coreRstOut=1 for 2 cycles; back to RUN with wdtCountOut=0.
- CLRWDT strobe every 10 cycles for 200 cycles -> never enters WRST; toOut stays 1. CLRWDT on the cycle with wdtCnt=15 -> no reset.
- SLEEP strobe -> coreEnOut=0, pdOut=0, stateOut=2; wakeIn=1 five cycles later -> WRST with toOut=1, pdOut=0.
- optionIn=4'b1001 (PSA=1, ratio 2), SLEEP -> WRST 32 cycles after SLEEP with toOut=0, pdOut=0; with wdtEnable=0 the block stays in SLEEP for 500 cycles.
- rst asserted during SLEEP and during WRST -> stateOut=0, toOut=1, pdOut=1, wdtCountOut=0 on the next edge.
